// File: rtl/cpu_ctrl.sv
// Instruction register and sequencing FSM for a small load/store-less CPU datapath.
// Control outputs are Moore outputs held in flops; each one reflects the current state and IR.
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        asel,
    output logic        bsel,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    typedef struct packed {
        logic       w;
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       asel;
        logic       bsel;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;

    // Control word for a given state and instruction; anything not named stays zero.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
        ctrl_t      c;
        logic [2:0] opcode;
        logic [1:0] op;
        logic       is_alu;
        logic       is_cmp;
        opcode = ir[15:13];
        op     = ir[12:11];
        is_alu = (opcode == 3'b101);
        is_cmp = is_alu && (op == 2'b01);
        c      = '0;
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c = '0;
            S_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            S_ALU: begin
                c.shift  = ir[4:3];
                c.bsel   = 1'b1;
                c.alu_op = is_alu ? op : 2'b00;
                c.asel   = is_alu && (op != 2'b11);
                c.loads  = is_cmp;
                c.loadc  = !is_cmp;
            end
            S_WR_REG: begin
                c.vsel     = 2'b11;
                c.writenum = ir[7:5];
                c.write    = 1'b1;
            end
            S_WR_IMM: begin
                c.vsel     = 2'b01;
                c.writenum = ir[10:8];
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state, IR capture and next control word.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if ((state_q == S_WAIT) && load) begin
            ir_d = in;
        end else begin
            ir_d = ir_q;
        end
        case (state_q)
            S_WAIT:   state_d = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                if ((ir_q[15:13] == 3'b110) && (ir_q[12:11] == 2'b10)) begin
                    state_d = S_WR_IMM;
                end else if (((ir_q[15:13] == 3'b110) && (ir_q[12:11] == 2'b00)) ||
                             ((ir_q[15:13] == 3'b101) && (ir_q[12:11] == 2'b11))) begin
                    state_d = S_GET_B;
                end else if (ir_q[15:13] == 3'b101) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            S_ALU:    state_d = ((ir_q[15:13] == 3'b101) && (ir_q[12:11] == 2'b01)) ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
        ctrl_d = decode_ctrl(state_d, ir_d);
    end

    // State, IR and registered control outputs; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
            ctrl_q  <= decode_ctrl(S_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign w        = ctrl_q.w;
    assign vsel     = ctrl_q.vsel;
    assign writenum = ctrl_q.writenum;
    assign readnum  = ctrl_q.readnum;
    assign write    = ctrl_q.write;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign shift    = ctrl_q.shift;
    assign ALUop    = ctrl_q.alu_op;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign sximm5   = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 No parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s  input  1  start; begins execution of the held instruction when sampled in WAIT.
REQ-005 load  input  1  instruction-register load enable.
REQ-006 in  input  16  instruction word.
REQ-007 w  output  1  idle flag; 1 exactly when the state is WAIT.
REQ-008 vsel  output  2  datapath write-back select: 00 mdata, 01 sximm8, 10 PC, 11 datapath_out.
REQ-009 writenum, readnum  output  3 each  register-file write and read addresses.
REQ-010 write, loada, loadb, loadc, loads  output  1 each  datapath strobes.
REQ-011 shift, ALUop  output  2 each  shifter and ALU operation selects.
REQ-012 asel, bsel  output  1 each  asel=1 selects A, asel=0 selects zero; bsel=1 selects the shifter output, bsel=0 selects sximm5.
REQ-013 sximm5, sximm8  output  16 each  sign-extended IR[4:0] and IR[7:0], combinational from IR.

Function
REQ-014 The 16-bit IR SHALL capture in on a clock edge when load=1 and state=WAIT.
REQ-015 load outside WAIT SHALL be ignored; IR holds its value.
REQ-016 Decode fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-017 Supported instructions:
- 110/10 MOV Rn,#imm8
- 110/00 MOV Rd,Rm{sh}
- 101/00 ADD
- 101/01 CMP
- 101/10 AND
- 101/11 MVN
REQ-018 States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM; outputs are Moore, decoded from state and IR.
REQ-019 WAIT: if s=1, next state is DECODE, otherwise stay. s outside WAIT SHALL be ignored.
REQ-020 If s and load are both 1 in WAIT, IR SHALL take the new word, and DECODE SHALL use the new value.
REQ-021 DECODE transitions:
- MOV imm → WR_IMM
- MOV reg or MVN → GET_B
- ADD, CMP or AND → GET_A
- any other opcode/op → WAIT, with no strobes asserted
REQ-022 GET_A: readnum=Rn, loada=1 → GET_B.
REQ-023 GET_B: readnum=Rm, loadb=1 → ALU.
REQ-024 ALU state: shift=sh, bsel=1.
- ALUop=op for opcode 101; ALUop=00 for MOV reg.
- asel=1 for ADD, CMP and AND; asel=0 for MOV reg and MVN.
REQ-025 ALU state, CMP: loads=1, loadc=0 → WAIT.
REQ-026 ALU state, all other instructions: loadc=1, loads=0 → WR_REG.
REQ-027 WR_REG: vsel=11, writenum=Rd, write=1 → WAIT.
REQ-028 WR_IMM: vsel=01, writenum=Rn, write=1 → WAIT.
REQ-029 Any output not specified for a state SHALL be 0, including strobes, vsel, readnum, writenum, shift, ALUop, asel and bsel.
REQ-030 Each strobe SHALL be high for exactly one cycle per instruction.
REQ-031 Busy cycles (w=0) per instruction:
- MOV imm: 2
- MOV reg, MVN: 4
- CMP: 4
- ADD, AND: 5
- undefined opcode: 1

Reset
REQ-032 reset=1 SHALL, at the next edge, set state=WAIT and IR=0x0000, overriding s and load.
REQ-033 Reset asserted mid-instruction SHALL abort it; no further write, loadc or loads for that instruction.
REQ-034 After reset, w=1 and all strobes are 0.

Verification
REQ-035 Reset: reset=1 for 1 cycle → w=1, write=0, IR=0x0000, sximm8=0x0000.
REQ-036 MOV R1,#7 and MOV #-1:
- load in=0xD107, then pulse s → DECODE, then WR_IMM with write=1, writenum=001, vsel=01, sximm8=0x0007, then w=1.
- in=0xD2FF → sximm8=0xFFFF.
REQ-037 ADD R2,R1,R0 LSL1 (in=0xA148) → strobes in order:
- GET_A: readnum=001, loada
- GET_B: readnum=000, loadb
- ALU: shift=01, ALUop=00, asel=1, bsel=1, loadc
- WR_REG: writenum=010, vsel=11, write
REQ-038 CMP R1,R0 (in=0xA900) → ALU state has loads=1 and loadc=0; no write; w=1 after 4 busy cycles.
REQ-039 Reset during GET_B of 0xA148 → WAIT next cycle, no write.
REQ-040 load=1 with in=0xFFFF while busy → IR unchanged.
REQ-041 in=0x0000 plus s → one DECODE cycle, then WAIT, all strobes 0.
